// File: rtl/rnbip_pkg.sv
// Shared types and constants for the fetch stage: state encoding, widths,
// the NOP opcode and the opcode length-field decode.
package rnbip_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned LEN_W   = 2;
   localparam int unsigned LEN_MSB = 7;
   localparam int unsigned LEN_LSB = 6;

   localparam logic [DATA_W-1:0] NOP_OP = 8'h00;

   localparam logic [LEN_W-1:0] LEN_0 = 2'd0;
   localparam logic [LEN_W-1:0] LEN_1 = 2'd1;
   localparam logic [LEN_W-1:0] LEN_2 = 2'd2;
   localparam logic [LEN_W-1:0] LEN_3 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_F_OP  = 3'd1,
      ST_F_OR1 = 3'd2,
      ST_F_OR2 = 3'd3,
      ST_DONE  = 3'd4
   } fetch_state_t;

   // Length field opcode[7:6]: 00 -> 1 byte, 01 -> 2 bytes, 1x -> 3 bytes.
   function automatic logic [LEN_W-1:0] instr_len(input logic [LEN_MSB-LEN_LSB:0] len_field);
      logic [LEN_W-1:0] len;
      case (len_field)
         2'b00:   len = LEN_1;
         2'b01:   len = LEN_2;
         default: len = LEN_3;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Combinational opcode length decode, applied to the opcode byte while it is
// still on the memory bus so the F_OP exit decision needs no extra cycle.
module fetch_len_decode
   import rnbip_pkg::*;
(
   input  logic [LEN_MSB-LEN_LSB:0] len_field_i,
   output logic [LEN_W-1:0]         len_o
);

   assign len_o = instr_len(len_field_i);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: walks the PC across opcode and operand bytes,
// latches them into IR/OR1/OR2 and hands the instruction to the control unit.
module instr_fetch_unit
   import rnbip_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              FETCH,
   input  logic              FLUSH,
   input  logic              EXEC_ACK,
   input  logic [ADDR_W-1:0] PC_in,
   input  logic [DATA_W-1:0] IM_data,
   input  logic              IM_ready,
   output logic [ADDR_W-1:0] IM_addr,
   output logic              I_PC,
   output logic [DATA_W-1:0] IR,
   output logic [DATA_W-1:0] OR1,
   output logic [DATA_W-1:0] OR2,
   output logic [LEN_W-1:0]  INSTR_LEN,
   output logic              INSTR_VALID,
   output logic              BUSY
);

   fetch_state_t      state_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] or1_q;
   logic [DATA_W-1:0] or2_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  op_len_d;
   logic [LEN_W-1:0]  ir_len;
   logic              fetching;

   fetch_len_decode u_len_decode (
      .len_field_i (IM_data[LEN_MSB:LEN_LSB]),
      .len_o       (op_len_d)
   );

   assign ir_len   = instr_len(ir_q[LEN_MSB:LEN_LSB]);
   assign fetching = (state_q == ST_F_OP) || (state_q == ST_F_OR1) || (state_q == ST_F_OR2);

   // One PC increment per byte consumed; a flush leaves the PC to its load path.
   assign I_PC    = fetching && IM_ready && !FLUSH;
   assign IM_addr = PC_in;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ir_q    <= NOP_OP;
         or1_q   <= '0;
         or2_q   <= '0;
         len_q   <= LEN_0;
      end else if (FLUSH) begin
         state_q <= ST_IDLE;
         ir_q    <= NOP_OP;
         or1_q   <= '0;
         or2_q   <= '0;
         len_q   <= LEN_0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (FETCH) begin
                  state_q <= ST_F_OP;
                  or1_q   <= '0;
                  or2_q   <= '0;
               end
            end
            ST_F_OP: begin
               if (IM_ready) begin
                  ir_q    <= IM_data;
                  len_q   <= op_len_d;
                  state_q <= (op_len_d == LEN_1) ? ST_DONE : ST_F_OR1;
               end
            end
            ST_F_OR1: begin
               if (IM_ready) begin
                  or1_q   <= IM_data;
                  state_q <= (ir_len == LEN_2) ? ST_DONE : ST_F_OR2;
               end
            end
            ST_F_OR2: begin
               if (IM_ready) begin
                  or2_q   <= IM_data;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Back-to-back fetch skips IDLE; unused operands restart at zero.
               if (EXEC_ACK) begin
                  if (FETCH) begin
                     state_q <= ST_F_OP;
                     or1_q   <= '0;
                     or2_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign IR          = ir_q;
   assign OR1         = or1_q;
   assign OR2         = or2_q;
   assign INSTR_LEN   = len_q;
   assign INSTR_VALID = (state_q == ST_DONE);
   assign BUSY        = fetching;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural PC and instruction memory.
module tb_instr_fetch_unit;
   import rnbip_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       fetch;
   logic       flush;
   logic       exec_ack;
   logic       im_ready;
   logic [7:0] pc;
   logic [7:0] im_data;
   logic [7:0] im_addr;
   logic       i_pc;
   logic [7:0] ir;
   logic [7:0] or1;
   logic [7:0] or2;
   logic [1:0] len;
   logic       valid;
   logic       busy;

   logic       l_pc;
   logic [7:0] pc_load;
   logic [7:0] mem [256];
   int         pulses = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         p0;
   int         edges;

   instr_fetch_unit dut (
      .CLK         (clk),
      .RST         (rst),
      .FETCH       (fetch),
      .FLUSH       (flush),
      .EXEC_ACK    (exec_ack),
      .PC_in       (pc),
      .IM_data     (im_data),
      .IM_ready    (im_ready),
      .IM_addr     (im_addr),
      .I_PC        (i_pc),
      .IR          (ir),
      .OR1         (or1),
      .OR2         (or2),
      .INSTR_LEN   (len),
      .INSTR_VALID (valid),
      .BUSY        (busy)
   );

   always #5 clk = ~clk;

   assign im_data = mem[im_addr];

   // Program counter model: load has priority over increment.
   always @(posedge clk or posedge rst) begin
      if (rst)       pc <= 8'h00;
      else if (l_pc) pc <= pc_load;
      else if (i_pc) pc <= pc + 8'd1;
   end

   always @(posedge clk) if (i_pc && !rst) pulses <= pulses + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_pc(input logic [7:0] v);
      l_pc    = 1'b1;
      pc_load = v;
      step();
      l_pc    = 1'b0;
   endtask

   task automatic start_fetch();
      fetch = 1'b1;
      step();
      fetch = 1'b0;
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (!valid && n < max) begin
         step();
         n++;
      end
      check("valid_wait", valid, 1);
   endtask

   task automatic ack();
      exec_ack = 1'b1;
      step();
      exec_ack = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      rst = 1'b1; fetch = 1'b0; flush = 1'b0; exec_ack = 1'b0;
      im_ready = 1'b1; l_pc = 1'b0; pc_load = 8'h00;
      step();
      step();
      check("rst_ir", ir, 8'h00);
      check("rst_or1", or1, 8'h00);
      check("rst_len", len, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ipc", i_pc, 0);
      rst = 1'b0;

      // Single-byte instruction
      mem[8'h10] = 8'h05;
      set_pc(8'h10);
      p0 = pulses;
      start_fetch();
      check("t1_busy", busy, 1);
      wait_valid(20, edges);
      check("t1_lat", edges, 1);
      check("t1_ir", ir, 8'h05);
      check("t1_or1", or1, 8'h00);
      check("t1_or2", or2, 8'h00);
      check("t1_len", len, 1);
      check("t1_pulses", pulses - p0, 1);
      check("t1_pc", pc, 8'h11);
      ack();
      check("t1_idle_valid", valid, 0);
      check("t1_idle_busy", busy, 0);

      // Three-byte instruction
      mem[8'h20] = 8'hC3; mem[8'h21] = 8'hAA; mem[8'h22] = 8'h55; mem[8'h23] = 8'h01;
      set_pc(8'h20);
      p0 = pulses;
      start_fetch();
      wait_valid(20, edges);
      check("t2_lat", edges, 3);
      check("t2_ir", ir, 8'hC3);
      check("t2_or1", or1, 8'hAA);
      check("t2_or2", or2, 8'h55);
      check("t2_len", len, 3);
      check("t2_pulses", pulses - p0, 3);
      check("t2_pc", pc, 8'h23);

      // Back-to-back ack+fetch; operands of the previous instruction must clear
      exec_ack = 1'b1; fetch = 1'b1;
      step();
      exec_ack = 1'b0; fetch = 1'b0;
      check("b2b_valid_drop", valid, 0);
      check("b2b_busy", busy, 1);
      check("b2b_or1_clr", or1, 8'h00);
      check("b2b_or2_clr", or2, 8'h00);
      step();
      check("b2b_valid", valid, 1);
      check("b2b_ir", ir, 8'h01);
      check("b2b_len", len, 1);
      check("b2b_pc", pc, 8'h24);
      fetch = 1'b1;
      repeat (5) step();
      check("hold_valid", valid, 1);
      check("hold_ir", ir, 8'h01);
      check("hold_pc", pc, 8'h24);
      fetch = 1'b0;
      ack();

      // Two-byte instruction with memory wait states on the operand
      mem[8'h30] = 8'h41; mem[8'h31] = 8'h99;
      set_pc(8'h30);
      p0 = pulses;
      start_fetch();
      step();
      im_ready = 1'b0;
      #1 check("t3_ipc_wait", i_pc, 0);
      step();
      step();
      check("t3_wait_valid", valid, 0);
      check("t3_wait_pc", pc, 8'h31);
      im_ready = 1'b1;
      wait_valid(20, edges);
      check("t3_lat", edges, 1);
      check("t3_ir", ir, 8'h41);
      check("t3_or1", or1, 8'h99);
      check("t3_or2", or2, 8'h00);
      check("t3_len", len, 2);
      check("t3_pulses", pulses - p0, 2);
      check("t3_pc", pc, 8'h32);
      ack();

      // Flush in F_OR1 while the PC is loaded
      mem[8'h40] = 8'hC0;
      set_pc(8'h40);
      p0 = pulses;
      start_fetch();
      step();
      flush = 1'b1; l_pc = 1'b1; pc_load = 8'h80;
      #1 check("t4_ipc_flush", i_pc, 0);
      step();
      flush = 1'b0; l_pc = 1'b0;
      check("t4_ir", ir, 8'h00);
      check("t4_valid", valid, 0);
      check("t4_busy", busy, 0);
      check("t4_len", len, 0);
      check("t4_pc", pc, 8'h80);
      check("t4_pulses", pulses - p0, 1);

      // FETCH and FLUSH together: flush wins
      fetch = 1'b1; flush = 1'b1;
      step();
      fetch = 1'b0; flush = 1'b0;
      check("ff_busy", busy, 0);
      step();
      check("ff_busy2", busy, 0);
      check("ff_pc", pc, 8'h80);

      // Address wrap across FF -> 00
      mem[8'hFF] = 8'h40; mem[8'h00] = 8'h7E;
      set_pc(8'hFF);
      start_fetch();
      wait_valid(20, edges);
      check("t6_ir", ir, 8'h40);
      check("t6_or1", or1, 8'h7E);
      check("t6_len", len, 2);
      check("t6_pc", pc, 8'h01);
      ack();

      // Asynchronous reset in F_OR2
      mem[8'h50] = 8'h80; mem[8'h51] = 8'h11; mem[8'h52] = 8'h22;
      set_pc(8'h50);
      start_fetch();
      step();
      step();
      check("t7_busy", busy, 1);
      check("t7_ipc", i_pc, 1);
      #2 rst = 1'b1;
      #1;
      check("t7_ipc_rst", i_pc, 0);
      check("t7_ir", ir, 8'h00);
      check("t7_or1", or1, 8'h00);
      check("t7_or2", or2, 8'h00);
      check("t7_len", len, 0);
      check("t7_valid", valid, 0);
      check("t7_busy_rst", busy, 0);
      step();
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
